// File: rtl/y_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package y_pkg;

  localparam int          INSTR_BYTES  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0080;

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_FETCH  = 2'd1,
    ST_SQUASH = 2'd2,
    ST_HOLD   = 2'd3
  } fetch_state_e;

  // Flat state codes for the state register, kept compatible with older
  // blocks that compare raw 2-bit state values.
  localparam logic [1:0] S_RST    = ST_RST;
  localparam logic [1:0] S_FETCH  = ST_FETCH;
  localparam logic [1:0] S_SQUASH = ST_SQUASH;
  localparam logic [1:0] S_HOLD   = ST_HOLD;

  // Decode-side buffer: one fetched word and its addresses.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } if_buf_t;

  // yMux2-style 32-bit select: s=0 -> a, s=1 -> b.
  function automatic logic [31:0] mux2(input logic [31:0] a,
                                       input logic [31:0] b,
                                       input logic        s);
    return s ? b : a;
  endfunction

endpackage

// File: rtl/y_fetch_if.sv
// Fetch-stage bus: instruction memory handshake, decode handoff and the
// execute-stage redirect. master = fetch stage, slave = its environment.
interface y_fetch_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] instr_in;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  modport master (
    input  redirect, redirect_pc, imem_ack, instr_in, id_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4
  );

  modport slave (
    output redirect, redirect_pc, imem_ack, instr_in, id_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4
  );
endinterface

// File: rtl/y_pc_next.sv
// Combinational next-PC select: redirect target (word aligned) beats the
// sequential if_pc4, which beats holding the current pc.
module y_pc_next
  import y_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] if_pc4,
  input  logic [31:0] redirect_pc,
  input  logic        take_redirect,
  input  logic        take_pc4,
  output logic [31:0] pc_next
);

  logic [31:0] tgt;
  logic [31:0] seq;

  // Low two bits of the target are dropped so the pc stays word aligned.
  assign tgt     = redirect_pc & ~32'h3;
  assign seq     = mux2(pc, if_pc4, take_pc4);
  assign pc_next = mux2(seq, tgt, take_redirect);

endmodule

// File: rtl/y_fetch.sv
// Instruction-fetch stage: owns the pc, issues one word request at a time,
// buffers a single instruction for decode and squashes wrong-path fetches.
module y_fetch
  import y_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
)(
  input  logic     clk,
  input  logic     rst_n,
  y_fetch_if.master bus
);

  localparam logic [31:0] RST_PC = RESET_PC & ~32'h3;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] sq_addr;   // address of the wrong-path request still in flight
  if_buf_t     ibuf;

  logic in_fetch, in_squash, in_hold;
  logic redir, valid, xfer, capture;

  assign in_fetch  = (state == S_FETCH);
  assign in_squash = (state == S_SQUASH);
  assign in_hold   = (state == S_HOLD);

  // Redirect is meaningless before the first fetch, so RST ignores it.
  assign redir   = bus.redirect && (state != S_RST);
  assign valid   = in_hold && !bus.redirect;
  assign xfer    = valid && bus.id_ready;
  assign capture = in_fetch && bus.imem_ack && !bus.redirect;

  y_pc_next u_pc_next (
    .pc            (pc),
    .if_pc4        (ibuf.pc4),
    .redirect_pc   (bus.redirect_pc),
    .take_redirect (redir),
    .take_pc4      (xfer),
    .pc_next       (pc_nxt)
  );

  // Next-state logic; redirect always outranks ack and id_ready.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.redirect)      state_nxt = bus.imem_ack ? S_FETCH : S_SQUASH;
        else if (bus.imem_ack) state_nxt = S_HOLD;
      end
      S_SQUASH: if (bus.imem_ack) state_nxt = S_FETCH;
      S_HOLD:   if (bus.redirect || xfer) state_nxt = S_FETCH;
      default:  state_nxt = S_RST;
    endcase
  end

  // State, pc and the pending wrong-path address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RST;
      pc      <= RST_PC;
      sq_addr <= RST_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // Keep presenting the abandoned address until memory answers it.
      if (in_fetch && bus.redirect && !bus.imem_ack) sq_addr <= pc;
    end
  end

  // Decode buffer: loads only on a right-path ack, otherwise stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibuf <= '0;
    end else if (capture) begin
      ibuf.instr <= bus.instr_in;
      ibuf.pc    <= pc;
      ibuf.pc4   <= pc + 32'(INSTR_BYTES);
    end
  end

  assign bus.imem_req  = in_fetch || in_squash;
  assign bus.imem_addr = in_squash ? sq_addr : pc;
  assign bus.if_valid  = valid;
  assign bus.if_instr  = ibuf.instr;
  assign bus.if_pc     = ibuf.pc;
  assign bus.if_pc4    = ibuf.pc4;

endmodule

// File: tb/tb_y_fetch.sv
// Bench for y_fetch: a cycle table for reset/stream/backpressure (with a
// wrap-around twin DUT checked against the same rows), then hand sequences
// for squash, redirects and mid-operation reset. A scoreboard checks every
// acked request address and every decode transfer.
module tb_y_fetch;
  import y_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y_fetch_if bm ();
  y_fetch_if bw ();

  y_fetch u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bm.master)
  );

  y_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bw.master)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC3A5_0F1E;
  endfunction

  // Twin DUT: zero-wait memory, shares id_ready, never redirected.
  assign bw.redirect    = 1'b0;
  assign bw.redirect_pc = 32'h0;
  assign bw.imem_ack    = bw.imem_req;
  assign bw.instr_in    = mem_word(bw.imem_addr);
  assign bw.id_ready    = bm.id_ready;

  int n_chk  = 0;
  int n_pass = 0;
  int lat    = 0;

  logic [31:0] q_req[$];
  logic [31:0] q_xfer[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Memory model: acks after 'lat' wait cycles, data derived from address.
  initial begin
    int cnt;
    cnt = 0;
    bm.imem_ack = 1'b0;
    bm.instr_in = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (bm.imem_req) begin
        if (cnt >= lat) begin bm.imem_ack = 1'b1; cnt = 0; end
        else begin bm.imem_ack = 1'b0; cnt++; end
      end else begin
        bm.imem_ack = 1'b0;
        cnt = 0;
      end
      bm.instr_in = bm.imem_ack ? mem_word(bm.imem_addr) : 32'hDEAD_BEEF;
    end
  end

  // Scoreboard: acked requests and decode transfers, in order.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (bm.imem_req && bm.imem_ack) begin
          if (q_req.size() == 0) begin
            n_chk++;
            $display("FAIL req_unexpected: got %h want none", bm.imem_addr);
          end else begin
            e = q_req.pop_front();
            chk("req_addr", bm.imem_addr, e);
          end
        end
        if (bm.if_valid && bm.id_ready) begin
          if (q_xfer.size() == 0) begin
            n_chk++;
            $display("FAIL xfer_unexpected: got pc %h want none", bm.if_pc);
          end else begin
            e = q_xfer.pop_front();
            chk("xfer_pc", bm.if_pc, e);
            chk("xfer_pc4", bm.if_pc4, e + 32'd4);
            chk("xfer_instr", bm.if_instr, mem_word(e));
          end
        end
      end
    end
  end

  // Called at a negedge: drain check, then reset for two cycles.
  task automatic do_reset(input int n_lat);
    rst_n = 1'b0;
    bm.redirect = 1'b0;
    bm.id_ready = 1'b0;
    chk("sb_req_drained", 32'(q_req.size()), 32'd0);
    chk("sb_xfer_drained", 32'(q_xfer.size()), 32'd0);
    q_req.delete();
    q_xfer.delete();
    repeat (2) @(negedge clk);
    lat   = n_lat;
    rst_n = 1'b1;
  endtask

  task automatic wait_empty(input int max_cyc);
    int k;
    k = 0;
    while ((q_req.size() != 0 || q_xfer.size() != 0) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    if (q_req.size() != 0 || q_xfer.size() != 0) begin
      n_chk++;
      $display("FAIL timeout: got %0d req %0d xfer pending want 0", q_req.size(), q_xfer.size());
      q_req.delete();
      q_xfer.delete();
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        id_ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_zero;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mkv(input logic r, input logic rdy, input logic rq,
                               input logic [31:0] a, input logic v,
                               input logic [31:0] p, input logic z);
    vec_t t;
    t.rst_n = r; t.id_ready = rdy; t.exp_req = rq; t.exp_addr = a;
    t.exp_valid = v; t.exp_pc = p; t.exp_zero = z;
    return t;
  endfunction

  initial begin
    //             rst rdy req addr          vld pc            zero
    tbl[0]  = mkv(0,  1,  0,  32'h0,        0,  32'h0,        1);
    tbl[1]  = mkv(1,  1,  1,  32'h80,       0,  32'h0,        1);
    tbl[2]  = mkv(1,  1,  0,  32'h0,        1,  32'h80,       0);
    tbl[3]  = mkv(1,  1,  1,  32'h84,       0,  32'h0,        0);
    tbl[4]  = mkv(1,  1,  0,  32'h0,        1,  32'h84,       0);
    tbl[5]  = mkv(1,  1,  1,  32'h88,       0,  32'h0,        0);
    tbl[6]  = mkv(1,  1,  0,  32'h0,        1,  32'h88,       0);
    for (int i = 7; i <= 11; i++)
      tbl[i] = mkv(1, 0,  0,  32'h0,        1,  32'h88,       0);
    tbl[12] = mkv(1,  1,  1,  32'h8C,       0,  32'h0,        0);
    tbl[13] = mkv(1,  1,  0,  32'h0,        1,  32'h8C,       0);
    tbl[14] = mkv(1,  0,  0,  32'h0,        1,  32'h8C,       0);

    bm.redirect    = 1'b0;
    bm.redirect_pc = 32'h0;
    bm.id_ready    = 1'b1;
    rst_n          = 1'b1;
    #1 rst_n       = 1'b0;

    // Reset, stream, backpressure; twin DUT sits 0x84 below (wraps through 0).
    q_req.push_back(32'h80); q_req.push_back(32'h84);
    q_req.push_back(32'h88); q_req.push_back(32'h8C);
    q_xfer.push_back(32'h80); q_xfer.push_back(32'h84); q_xfer.push_back(32'h88);
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      rst_n       = tbl[i].rst_n;
      bm.id_ready = tbl[i].id_ready;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("t%0d_req", i), 32'(bm.imem_req), 32'(tbl[i].exp_req));
      chk($sformatf("t%0d_valid", i), 32'(bm.if_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("w%0d_req", i), 32'(bw.imem_req), 32'(tbl[i].exp_req));
      chk($sformatf("w%0d_valid", i), 32'(bw.if_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_req) begin
        chk($sformatf("t%0d_addr", i), bm.imem_addr, tbl[i].exp_addr);
        chk($sformatf("w%0d_addr", i), bw.imem_addr, tbl[i].exp_addr - 32'h84);
      end
      if (tbl[i].exp_valid) begin
        chk($sformatf("t%0d_pc", i), bm.if_pc, tbl[i].exp_pc);
        chk($sformatf("t%0d_instr", i), bm.if_instr, mem_word(tbl[i].exp_pc));
        chk($sformatf("w%0d_pc", i), bw.if_pc, tbl[i].exp_pc - 32'h84);
        chk($sformatf("w%0d_pc4", i), bw.if_pc4, tbl[i].exp_pc - 32'h80);
      end
      if (tbl[i].exp_zero) begin
        chk($sformatf("t%0d_pc_rst", i), bm.if_pc, 32'h0);
        chk($sformatf("t%0d_pc4_rst", i), bm.if_pc4, 32'h0);
        chk($sformatf("t%0d_instr_rst", i), bm.if_instr, 32'h0);
      end
    end

    // Squash: redirect to 0x1003 while waiting on a slow ack.
    do_reset(3);
    bm.id_ready = 1'b1;
    q_req.push_back(32'h80); q_req.push_back(32'h1000);
    q_xfer.push_back(32'h1000);
    @(negedge clk);
    chk("sq_req_first", bm.imem_addr, 32'h80);
    bm.redirect = 1'b1; bm.redirect_pc = 32'h1003;
    @(negedge clk);
    bm.redirect = 1'b0;
    chk("sq_req_held", 32'(bm.imem_req), 32'd1);
    chk("sq_addr_old", bm.imem_addr, 32'h80);
    chk("sq_valid", 32'(bm.if_valid), 32'd0);
    wait_empty(40);

    // Redirect in HOLD with id_ready high: no transfer that cycle.
    do_reset(0);
    q_req.push_back(32'h80); q_req.push_back(32'h2000);
    q_xfer.push_back(32'h2000);
    @(negedge clk);
    @(negedge clk);
    chk("hold_valid", 32'(bm.if_valid), 32'd1);
    bm.id_ready = 1'b1; bm.redirect = 1'b1; bm.redirect_pc = 32'h2000;
    #1;
    chk("hold_redir_valid", 32'(bm.if_valid), 32'd0);
    @(negedge clk);
    bm.redirect = 1'b0;
    chk("hold_redir_req", 32'(bm.imem_req), 32'd1);
    chk("hold_redir_addr", bm.imem_addr, 32'h2000);
    wait_empty(20);

    // Redirect and ack in the same FETCH cycle: data dropped, refetch target.
    do_reset(0);
    bm.id_ready = 1'b1;
    q_req.push_back(32'h80); q_req.push_back(32'h3000);
    q_xfer.push_back(32'h3000);
    @(negedge clk);
    bm.redirect = 1'b1; bm.redirect_pc = 32'h3002;
    @(negedge clk);
    bm.redirect = 1'b0;
    chk("fa_addr", bm.imem_addr, 32'h3000);
    chk("fa_valid", 32'(bm.if_valid), 32'd0);
    wait_empty(20);

    // Asynchronous reset while a squashed request is outstanding.
    do_reset(5);
    bm.id_ready = 1'b1;
    @(negedge clk);
    bm.redirect = 1'b1; bm.redirect_pc = 32'h4000;
    @(negedge clk);
    bm.redirect = 1'b0;
    @(negedge clk);
    chk("mr_req_before", 32'(bm.imem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_req_drop", 32'(bm.imem_req), 32'd0);
    chk("mr_valid_drop", 32'(bm.if_valid), 32'd0);
    chk("mr_pc_clr", bm.if_pc, 32'h0);
    lat = 0;
    q_req.push_back(32'h80);
    q_xfer.push_back(32'h80);
    @(negedge clk);
    rst_n = 1'b1;
    wait_empty(20);

    do_reset(0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
